// File: rtl/dsc_mul_rr_sched_if.sv
// Request/response bundle between the requester fabric and the multiplier scheduler.
// The slave side is the scheduler; the master side is the requester fabric.
interface dsc_mul_rr_sched_if #(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 1,
    parameter int NUM_REQ    = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0] req_data;
    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic [ID_W-1:0]                          rsp_id;
    logic [WXIP1-1:0]                         rsp_data;
    logic                                     rsp_err;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/dsc_mul_rr_sched.sv
// Round-robin scheduler time-sharing one multiplier core among NUM_REQ requesters,
// with a run watchdog that aborts operations whose core never reports done.
module dsc_mul_rr_sched #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_INPUTS     = 2,
    parameter int WXIP1          = 1,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    dsc_mul_rr_sched_if.slave     bus,
    output logic                  core_rst,
    output logic                  core_en,
    output logic [DATA_WIDTH-1:0] core_data_in [NUM_INPUTS],
    input  logic [WXIP1-1:0]      core_data_out,
    input  logic                  core_done,
    output logic                  busy
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t                state_r;
    logic [ID_W-1:0]       rr_ptr_r;
    logic [ID_W-1:0]       rsp_id_r;
    logic [WD_W-1:0]       wd_cnt_r;
    logic [DATA_WIDTH-1:0] ops_r [NUM_INPUTS];
    logic                  clr_r;
    logic                  en_r;
    logic                  busy_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [WXIP1-1:0]      rsp_data_r;

    logic [ID_W-1:0]       grant_s;
    logic                  grant_vld_s;
    logic [ID_W-1:0]       next_ptr_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic [DATA_WIDTH-1:0] sel_ops_s [NUM_INPUTS];

    // Rotating priority search: walking downward from the far end lets the
    // requester closest to rr_ptr overwrite the others.
    always_comb begin
        grant_s     = '0;
        grant_vld_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx         = (int'(rr_ptr_r) + k) % NUM_REQ;
            grant_s     = bus.req_valid[idx] ? ID_W'(idx) : grant_s;
            grant_vld_s = grant_vld_s | bus.req_valid[idx];
        end
    end

    // One-hot accept, next pointer and the granted requester's operand slice
    always_comb begin
        ready_s    = (state_r == IDLE && grant_vld_s)
                   ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_s) : '0;
        next_ptr_s = (grant_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_s + ID_W'(1);
        for (int j = 0; j < NUM_INPUTS; j++) begin
            sel_ops_s[j] = bus.req_data[(int'(grant_s) * NUM_INPUTS + j) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scheduler FSM with registered core controls, result capture and watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            rsp_id_r    <= '0;
            wd_cnt_r    <= '0;
            clr_r       <= 1'b0;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            for (int j = 0; j < NUM_INPUTS; j++) begin
                ops_r[j] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        ops_r    <= sel_ops_s;
                        rsp_id_r <= grant_s;
                        rr_ptr_r <= next_ptr_s;
                        clr_r    <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= CLR;
                    end
                end
                CLR: begin
                    clr_r    <= 1'b0;
                    en_r     <= 1'b1;
                    wd_cnt_r <= '0;
                    state_r  <= RUN;
                end
                RUN: begin
                    // done is checked first so it wins over a coinciding timeout
                    if (core_done) begin
                        rsp_data_r  <= core_data_out;
                        rsp_err_r   <= 1'b0;
                        en_r        <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end else if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        en_r        <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RSP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    clr_r       <= 1'b0;
                    en_r        <= 1'b0;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign core_rst      = rst | clr_r;
    assign core_en       = en_r;
    assign core_data_in  = ops_r;
    assign busy          = busy_r;
    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule
